// File: rtl/status_fifo.sv
// Single-clock byte FIFO with registered full/empty/count flags and registered read data.
// Define STATUS_FIFO_ERR_EN to enable the sticky overflow/underflow error flags.
module status_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              rd_ok;
    logic              wr_ok;

    // Accept decisions use only registered flags, so a write into a full FIFO
    // is allowed exactly when it is paired with an accepted read.
    always_comb begin
        rd_ok      = rd_en & ~empty_q;
        wr_ok      = wr_en & (~full_q | rd_ok);

        wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(wr_ok);
        rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(rd_ok);

        count_d    = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d     = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d    = (count_d == '0);

        rd_valid_d = rd_ok;
        rd_data_d  = rd_ok ? mem_q[rd_ptr_q[ADDR_W-1:0]] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

`ifdef STATUS_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (wr_en & ~wr_ok) | (overflow_q & ~err_clr);
        underflow_d = (rd_en & empty_q) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_status_fifo.sv
// Bench for status_fifo: a constant vector table, directed corner sequences,
// and random traffic checked against a queue-based model of the FIFO.
module tb_status_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef STATUS_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          err_clr;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_udf;

    typedef struct {
        bit            wr;
        logic [DW-1:0] data;
        bit            rd;
        bit            clr;
        int            exp_count;
        bit            exp_full;
        bit            exp_empty;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
        bit            exp_udf;
    } vec_t;

    vec_t tbl[7];

    status_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the reference queue at the edge, settle #1 after.
    task automatic apply_stimulus(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        int sz;
        bit rok;
        bit wok;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        err_clr = clr;
        @(posedge clk);
        sz  = model_q.size();
        rok = rd && (sz != 0);
        wok = wr && ((sz < DEPTH) || rok);
        if (ERR_EN) begin
            exp_ovf = (wr && !wok) || (exp_ovf && !clr);
            exp_udf = (rd && sz == 0) || (exp_udf && !clr);
        end
        if (rok) begin
            exp_data  = model_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (wok) model_q.push_back(d);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_count"}, 32'(count), 32'(model_q.size()));
        check_output({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check_output({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check_output({tag, "_rd_valid"}, 32'(rd_valid), 32'(exp_valid));
        check_output({tag, "_rd_data"}, 32'(rd_data), 32'(exp_data));
        check_output({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check_output({tag, "_underflow"}, 32'(underflow), 32'(exp_udf));
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr, input string tag);
        apply_stimulus(wr, d, rd, clr);
        check_model(tag);
    endtask

    // Assert reset between edges and confirm the flags change without a clock.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        wr_en = 1'b0;
        rd_en = 1'b0;
        err_clr = 1'b0;
        rst = 1'b0;
        #1;
        model_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        check_model(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        err_clr   = 1'b0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;

        //              wr  data   rd clr cnt full emp vld data   udf
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h22, ERR_EN};
        tbl[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h22, ERR_EN};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h3C, ERR_EN};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_count", 32'(count), 0);
        check_output("reset_full", 32'(full), 0);
        check_output("reset_empty", 32'(empty), 1);
        check_output("reset_rd_valid", 32'(rd_valid), 0);
        check_output("reset_rd_data", 32'(rd_data), 0);
        check_output("reset_overflow", 32'(overflow), 0);
        check_output("reset_underflow", 32'(underflow), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(tbl[i].wr, tbl[i].data, tbl[i].rd, tbl[i].clr);
            check_output($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            check_output($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
            check_output($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].exp_empty));
            check_output($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
            check_output($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
            check_output($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].exp_udf));
            check_output($sformatf("tbl%0d_overflow", i), 32'(overflow), 0);
        end

        do_reset("rst_a");

        // Fill to full with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
            if (i == 0) check_output("empty_falls", 32'(empty), 0);
            if (i == DEPTH - 2) check_output("not_full_yet", 32'(full), 0);
        end
        check_output("full_after_fill", 32'(full), 1);
        check_output("count_after_fill", 32'(count), DEPTH);

        step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf_drop");
        check_output("ovf_count", 32'(count), DEPTH);
        check_output("ovf_flag", 32'(overflow), 32'(ERR_EN));
        step(1'b0, 8'h00, 1'b0, 1'b0, "ovf_hold");
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
        check_output("ovf_cleared", 32'(overflow), 0);

        step(1'b1, 8'h55, 1'b1, 1'b0, "full_rw");
        check_output("full_rw_data", 32'(rd_data), 8'h00);
        check_output("full_rw_full", 32'(full), 1);
        check_output("full_rw_count", 32'(count), DEPTH);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
            if (i < DEPTH - 1) check_output("drain_order", 32'(rd_data), 32'(i + 1));
        end
        check_output("drain_last", 32'(rd_data), 8'h55);
        check_output("drain_empty", 32'(empty), 1);
        check_output("drain_count", 32'(count), 0);

        step(1'b1, 8'h3C, 1'b1, 1'b0, "empty_rw");
        check_output("empty_rw_valid", 32'(rd_valid), 0);
        check_output("empty_rw_udf", 32'(underflow), 32'(ERR_EN));
        step(1'b0, 8'h00, 1'b1, 1'b0, "empty_rw_next");
        check_output("empty_rw_data", 32'(rd_data), 8'h3C);
        check_output("empty_rw_nvalid", 32'(rd_valid), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "udf_clr");

        // Sustained simultaneous traffic at full and at occupancy 1.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "refill");
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, "sust_full");
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "down_to_one");
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, "sust_one");

        // Random traffic with pointer wrap and a mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rst_mid");
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 5, "rand");
        end
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, "tail");
        do_reset("rst_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_fifo.md
# status_fifo

Synchronous byte FIFO that buffers data on a single clock and publishes registered `full` / `empty` flags. It sits directly upstream of the UART status transmitter. That transmitter sends an ASCII 'F' on each rising edge of `full` and an ASCII 'E' on each rising edge of `empty`, so flag timing and glitch-freedom are contractual.

## Interface
- `DATA_W`, 8: data width in bits.
- `DEPTH`, 16: number of entries; must be a power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH): pointer index width; derived, do not override.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: write request.
- `wr_data`  in  DATA_W: write data, sampled with `wr_en`.
- `rd_en`  in  1: read request.
- `rd_data`  out  DATA_W: registered read data.
- `rd_valid`  out  1: `rd_data` holds a newly popped word this cycle.
- `full`  out  1: registered; DEPTH entries stored.
- `empty`  out  1: registered; zero entries stored.
- `count`  out  ADDR_W+1: registered occupancy, 0..DEPTH.
- `err_clr`  in  1: clears sticky error flags.
- `overflow`  out  1: sticky; a write was dropped.
- `underflow`  out  1: sticky; a read was refused.

## Operation
- Storage is a DEPTH x DATA_W register array.
- `wr_ptr` and `rd_ptr` are each ADDR_W+1 bits. The low ADDR_W bits index the array. The MSB is a wrap bit, and the pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated on the registered flags:
  - `rd_ok = rd_en & !empty`.
  - `wr_ok = wr_en & (!full | rd_ok)`.
- A write into a full FIFO succeeds only when paired with an accepted read in the same cycle.
- A read from an empty FIFO is refused even when a write occurs in the same cycle. The written word becomes readable on the next cycle.
- Occupancy update:
  - `wr_ok` only: `count + 1`.
  - `rd_ok` only: `count - 1`.
  - Both or neither: unchanged.
- `full` and `empty` are computed from next-state `count` and registered, so they never glitch.
  - `full` rises in the cycle after the write that fills the last slot.
  - `empty` rises in the cycle after the read that pops the last word.
- On `rd_ok`: `rd_data <= mem[rd_ptr]`, `rd_valid <= 1`. Otherwise `rd_valid <= 0` and `rd_data` holds its value.
- Refused operations leave pointers, `count` and memory untouched.
- Reset values: `wr_ptr = rd_ptr = 0`, `count = 0`, `full = 0`, `empty = 1`, `rd_data = 0`, `rd_valid = 0`, `overflow = underflow = 0`.
- Memory contents are not reset.
- Reset mid-operation discards all contents. Flags return to their reset values asynchronously.
- `empty = 1` immediately after reset is intended. Downstream edge detectors report it once.

## Timing
- Write-to-read latency: a word written in cycle N may be popped in cycle N+1. It appears on `rd_data` with `rd_valid = 1` at the end of cycle N+1.
- Read latency: 1 cycle from `rd_en` to `rd_data` / `rd_valid`.
- Flags and `count` settle 1 cycle after the accepted operation. Never combinational from `wr_en` or `rd_en`.
- Sustained simultaneous read+write at any occupancy from 1 to DEPTH: throughput is one word per cycle and the flags stay constant.

## Configuration
- Macro: `STATUS_FIFO_ERR_EN`.
- Defined:
  - `overflow` sets on `wr_en & !wr_ok`.
  - `underflow` sets on `rd_en & empty`.
  - Both remain set until `err_clr` is high for one cycle. If a set and `err_clr` occur in the same cycle, set wins.
- Undefined:
  - `overflow` and `underflow` are tied to 0 and `err_clr` is ignored.
  - Refused operations are silently dropped.
  - The port list is identical in both builds.

## Test plan
- Reset, then write 0x00..0x0F on consecutive cycles (DEPTH=16) -> `full` rises the cycle after 0x0F; `count = 16`; `empty` falls the cycle after the first write.
- Read 16 times -> `rd_data` is 0x00..0x0F in order, each with `rd_valid = 1`; `empty` rises the cycle after the 16th read; `count = 0`.
- When full, write 0xAA without reading -> the write is dropped and `count` stays at 16. With ERR_EN, `overflow = 1` until `err_clr`.
- When full, write 0x55 and read simultaneously -> oldest word output; `full` stays 1, `count` stays 16; 0x55 is read last after a full drain.
- When empty, assert `rd_en` and `wr_en` (0x3C) together -> read refused (`rd_valid = 0`; `underflow = 1` with ERR_EN); the next-cycle read returns 0x3C.
- Drive wr/rd through more than 2*DEPTH words with pointer wrap, then assert `rst` mid-stream -> data order is preserved across the wrap; after reset, `empty = 1`, `full = 0`, `count = 0`, `rd_valid = 0`.
